core_decode_stage: RTL and testbench
====================================

Name: core_decode_stage

Overview:
- Decode stage of the RV32I core: takes a fetched instruction and its PC, decodes it, and reads the register file.
- Registers a fully resolved execution bundle for the execution unit: ALU operation code, both ALU operands, destination register and control flags.
- Sits between fetch and the execution unit.
- One pipeline register, with a valid/ready handshake on each side and a flush input.

Parameters:
- RESET_PC, 32'h0000_0000: value loaded into pc_o on reset.

Ports:
- clk  in  1  core clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid_i  in  1  fetch presents a valid instruction
- in_ready_o  out  1  stage accepts the instruction this cycle
- instr_i  in  32  instruction word
- pc_i  in  32  PC of instr_i
- flush_i  in  1  discard held and incoming instructions (taken branch/jump)
- rs1_addr_o  out  5  register-file read address 1 (instr_i[19:15]), combinational
- rs2_addr_o  out  5  register-file read address 2 (instr_i[24:20]), combinational
- rs1_data_i  in  REG_DATA_WIDTH  combinational register-file read data 1
- rs2_data_i  in  REG_DATA_WIDTH  combinational register-file read data 2
- out_valid_o  out  1  bundle valid to the execution unit
- out_ready_i  in  1  execution unit consumes the bundle
- alu_op_o  out  ALU_OP_WIDTH  ALU operation (ALU_OP_* codes)
- s1_o  out  REG_DATA_WIDTH  ALU operand 1
- s2_o  out  REG_DATA_WIDTH  ALU operand 2
- imm_o  out  32  sign-extended immediate (branch/jump target, store offset)
- store_data_o  out  REG_DATA_WIDTH  rs2 value for stores
- rd_o  out  5  destination register
- reg_we_o  out  1  write rd; forced 0 when rd = x0
- mem_rd_o / mem_wr_o  out  1 / 1  load / store
- mem_funct3_o  out  3  access size and sign
- branch_o / jal_o / jalr_o  out  1 / 1 / 1  control-transfer type
- br_cond_o  out  3  branch funct3
- pc_o  out  32  PC of the bundle
- illegal_o  out  1  unsupported encoding

Behaviour:
- Reset values:
  - out_valid_o = 0; pc_o = RESET_PC.
  - All other registered outputs = 0.
  - alu_op_o = ALU_OP_ADD.
- Handshake:
  - in_ready_o = !out_valid_o || out_ready_i.
  - A transfer occurs on in_valid_i && in_ready_o.
  - Latency: 1 cycle from accept to out_valid_o.
  - The bundle is held stable while out_valid_o && !out_ready_i.
- Flush:
  - The next cycle has out_valid_o = 0.
  - The instruction presented in the same cycle is dropped.
  - Flush has priority over accept.
  - Reset has priority over flush.
- Operand and ALU-op selection:
  - LUI: s1 = 0, s2 = imm_u, ADD.
  - AUIPC: s1 = pc, s2 = imm_u, ADD.
  - JAL/JALR: s1 = pc, s2 = 4, ADD (link value). imm_o = imm_j / imm_i.
  - BRANCH: s1 = rs1, s2 = rs2, reg_we = 0.
    - BEQ/BNE use SUB.
    - BLT/BGE use SLT.
    - BLTU/BGEU use SLTU.
    - imm_o = imm_b.
  - LOAD: s1 = rs1, s2 = imm_i, ADD, mem_rd = 1.
  - STORE: s1 = rs1, s2 = imm_s, ADD, mem_wr = 1, reg_we = 0.
  - OP-IMM: s2 = imm_i; ALU op from funct3.
    - SRLI/SRAI are selected by instr[30].
    - SLLI/SRLI/SRAI with instr[31:25] not in {0, 0x20 for SRAI} are illegal.
  - OP: s2 = rs2.
    - ADD/SUB and SRL/SRA are selected by instr[30].
    - Any other non-zero funct7 is illegal.
  - MISC-MEM (FENCE): valid NOP with all write enables 0.
- Illegal encodings:
  - Cover SYSTEM, unknown opcodes, undefined funct3 (branch 2/3, load 3/6/7, store ≥3, JALR ≠0) and bad funct7.
  - Result: illegal_o = 1; reg_we, mem_rd and mem_wr = 0; alu_op = ADD.
  - The bundle is still delivered.
- Immediates: all sign-extended to 32 bits from instr[31].
- Register-file data is sampled in the accept cycle. No bypassing inside this block; hazards are handled externally.

Decomposition:
- Shared defines file (src/defines.vh) gains:
  - opcode constants: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM;
  - IMM_* type selectors.
- Existing ALU_OP_*, ALU_OP_WIDTH and REG_DATA_WIDTH are reused.
- One sub-module, core_decode_imm_gen: combinational instr → imm_i/s/b/u/j.

Test Plan:
- After reset, 0x00500093 (addi x1,x0,5) with rs1_data = 0 → next cycle: out_valid = 1, alu_op = ADD, s1 = 0, s2 = 5, rd = 1, reg_we = 1.
- 0x402081B3 (sub x3,x1,x2), rs1 = 10, rs2 = 3 → alu_op = SUB, s1 = 10, s2 = 3, rd = 3; 0x40335293 (srai x5,x6,3) → SRA, s2[4:0] = 3.
- 0x00208463 (beq x1,x2,+8) at pc 0x100 → branch = 1, alu_op = SUB, imm = 8, reg_we = 0, pc_o = 0x100.
- 0xFFC12203 (lw x4,-4(x2)) → mem_rd = 1, s2 = 0xFFFF_FFFC, mem_funct3 = 2; 0x12345397 (auipc x7) at pc 0x40 → s1 = 0x40, s2 = 0x1234_5000.
- out_ready_i = 0 for 3 cycles with in_valid_i = 1 → bundle stable, in_ready_o = 0, no instruction lost or duplicated; flush_i with in_valid_i = 1 → next cycle out_valid = 0.
- 0x00000073 (ecall) and 0x0000007F → illegal_o = 1, reg_we = 0; rd = x0 with addi → reg_we = 0.

Source files
------------

// File: rtl/core_decode_stage_pkg.sv
// Shared definitions for the RV32I decode stage: data widths, ALU operation
// codes, base opcodes, immediate-type selectors and the registered bundle.
package core_decode_stage_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int ALU_OP_WIDTH   = 4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'd9;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0]   alu_op;
    logic [REG_DATA_WIDTH-1:0] s1;
    logic [REG_DATA_WIDTH-1:0] s2;
    logic [31:0]               imm;
    logic [REG_DATA_WIDTH-1:0] store_data;
    logic [4:0]                rd;
    logic                      reg_we;
    logic                      mem_rd;
    logic                      mem_wr;
    logic [2:0]                mem_funct3;
    logic                      branch;
    logic                      jal;
    logic                      jalr;
    logic [2:0]                br_cond;
    logic                      illegal;
    logic [31:0]               pc;
  } bundle_t;

  // Register-register and register-immediate ops share the funct3 mapping;
  // alt selects SUB over ADD and SRA over SRL.
  function automatic logic [ALU_OP_WIDTH-1:0] alu_from_funct3(input logic [2:0] f3,
                                                               input logic       alt);
    logic [ALU_OP_WIDTH-1:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_OP_SUB : ALU_OP_ADD;
      3'b001:  op = ALU_OP_SLL;
      3'b010:  op = ALU_OP_SLT;
      3'b011:  op = ALU_OP_SLTU;
      3'b100:  op = ALU_OP_XOR;
      3'b101:  op = alt ? ALU_OP_SRA : ALU_OP_SRL;
      3'b110:  op = ALU_OP_OR;
      default: op = ALU_OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/core_decode_imm_gen.sv
// Immediate generator: extracts the five RV32I immediate formats from an
// instruction word, each sign-extended from instr[31].
// Ports: instr (instruction bits 31:7) -> imm_i/imm_s/imm_b/imm_u/imm_j.
module core_decode_imm_gen
  import core_decode_stage_pkg::*;
(
  input  logic [31:7] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/core_decode_stage.sv
// RV32I decode stage: decodes the fetched instruction, reads the register
// file combinationally and registers a resolved execution bundle.
// Ports: clk/rst (sync, active high); fetch side in_valid_i/in_ready_o,
// instr_i, pc_i, flush_i; register-file rs1/rs2 address out, data in;
// execution side out_valid_o/out_ready_i plus the bundle fields.
module core_decode_stage
  import core_decode_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [31:0]               instr_i,
  input  logic [31:0]               pc_i,
  input  logic                      flush_i,
  output logic [4:0]                rs1_addr_o,
  output logic [4:0]                rs2_addr_o,
  input  logic [REG_DATA_WIDTH-1:0] rs1_data_i,
  input  logic [REG_DATA_WIDTH-1:0] rs2_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [ALU_OP_WIDTH-1:0]   alu_op_o,
  output logic [REG_DATA_WIDTH-1:0] s1_o,
  output logic [REG_DATA_WIDTH-1:0] s2_o,
  output logic [31:0]               imm_o,
  output logic [REG_DATA_WIDTH-1:0] store_data_o,
  output logic [4:0]                rd_o,
  output logic                      reg_we_o,
  output logic                      mem_rd_o,
  output logic                      mem_wr_o,
  output logic [2:0]                mem_funct3_o,
  output logic                      branch_o,
  output logic                      jal_o,
  output logic                      jalr_o,
  output logic [2:0]                br_cond_o,
  output logic [31:0]               pc_o,
  output logic                      illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  imm_sel_e    imm_sel;
  bundle_t     dec;
  bundle_t     bundle_r;
  logic        valid_r;

  assign opcode     = instr_i[6:0];
  assign funct3     = instr_i[14:12];
  assign funct7     = instr_i[31:25];
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  core_decode_imm_gen u_imm_gen (
    .instr (instr_i[31:7]),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  always_comb begin
    dec            = '0;
    imm_sel        = IMM_I;
    dec.alu_op     = ALU_OP_ADD;
    dec.s1         = rs1_data_i;
    dec.s2         = rs2_data_i;
    dec.store_data = rs2_data_i;
    dec.rd         = instr_i[11:7];
    dec.mem_funct3 = funct3;
    dec.br_cond    = funct3;
    dec.pc         = pc_i;
    case (opcode)
      OPC_LUI: begin
        imm_sel = IMM_U; dec.s1 = '0; dec.s2 = imm_u; dec.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        imm_sel = IMM_U; dec.s1 = pc_i; dec.s2 = imm_u; dec.reg_we = 1'b1;
      end
      OPC_JAL: begin
        imm_sel = IMM_J; dec.s1 = pc_i; dec.s2 = 32'd4; dec.reg_we = 1'b1; dec.jal = 1'b1;
      end
      OPC_JALR: begin
        dec.s1 = pc_i; dec.s2 = 32'd4; dec.reg_we = 1'b1; dec.jalr = 1'b1;
        dec.illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        imm_sel    = IMM_B;
        dec.branch = 1'b1;
        case (funct3[2:1])
          2'b00:   dec.alu_op = ALU_OP_SUB;
          2'b10:   dec.alu_op = ALU_OP_SLT;
          2'b11:   dec.alu_op = ALU_OP_SLTU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.s2 = imm_i; dec.mem_rd = 1'b1; dec.reg_we = 1'b1;
        dec.illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        imm_sel = IMM_S; dec.s2 = imm_s; dec.mem_wr = 1'b1;
        dec.illegal = (funct3 > 3'b010);
      end
      OPC_OP_IMM: begin
        // Bit 30 is only an opcode bit for shifts; elsewhere it is immediate.
        dec.s2     = imm_i;
        dec.reg_we = 1'b1;
        dec.alu_op = alu_from_funct3(funct3, (funct3 == 3'b101) && instr_i[30]);
        if (funct3 == 3'b001)
          dec.illegal = (funct7 != 7'h00);
        else if (funct3 == 3'b101)
          dec.illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OPC_OP: begin
        dec.reg_we  = 1'b1;
        dec.alu_op  = alu_from_funct3(funct3, instr_i[30]);
        dec.illegal = !((funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_MISC_MEM: ;
      default: dec.illegal = 1'b1;
    endcase

    case (imm_sel)
      IMM_S:   dec.imm = imm_s;
      IMM_B:   dec.imm = imm_b;
      IMM_U:   dec.imm = imm_u;
      IMM_J:   dec.imm = imm_j;
      default: dec.imm = imm_i;
    endcase

    // An illegal instruction still travels down the pipe, but must not
    // change architectural state or redirect control flow.
    if (dec.illegal) begin
      dec.alu_op = ALU_OP_ADD;
      dec.reg_we = 1'b0;
      dec.mem_rd = 1'b0;
      dec.mem_wr = 1'b0;
      dec.branch = 1'b0;
      dec.jal    = 1'b0;
      dec.jalr   = 1'b0;
    end
    if (dec.rd == 5'd0)
      dec.reg_we = 1'b0;
  end

  assign in_ready_o = !valid_r || out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r     <= 1'b0;
      bundle_r    <= '0;
      bundle_r.pc <= RESET_PC;
    end else if (flush_i) begin
      valid_r <= 1'b0;
    end else if (in_ready_o) begin
      valid_r <= in_valid_i;
      if (in_valid_i)
        bundle_r <= dec;
    end
  end

  assign out_valid_o  = valid_r;
  assign alu_op_o     = bundle_r.alu_op;
  assign s1_o         = bundle_r.s1;
  assign s2_o         = bundle_r.s2;
  assign imm_o        = bundle_r.imm;
  assign store_data_o = bundle_r.store_data;
  assign rd_o         = bundle_r.rd;
  assign reg_we_o     = bundle_r.reg_we;
  assign mem_rd_o     = bundle_r.mem_rd;
  assign mem_wr_o     = bundle_r.mem_wr;
  assign mem_funct3_o = bundle_r.mem_funct3;
  assign branch_o     = bundle_r.branch;
  assign jal_o        = bundle_r.jal;
  assign jalr_o       = bundle_r.jalr;
  assign br_cond_o    = bundle_r.br_cond;
  assign pc_o         = bundle_r.pc;
  assign illegal_o    = bundle_r.illegal;

endmodule

// File: tb/tb_core_decode_stage.sv
// Directed testbench for core_decode_stage with hand-computed expectations.
module tb_core_decode_stage;
  import core_decode_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [31:0]               instr_i;
  logic [31:0]               pc_i;
  logic                      flush_i;
  logic [4:0]                rs1_addr_o;
  logic [4:0]                rs2_addr_o;
  logic [REG_DATA_WIDTH-1:0] rs1_data_i;
  logic [REG_DATA_WIDTH-1:0] rs2_data_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [ALU_OP_WIDTH-1:0]   alu_op_o;
  logic [REG_DATA_WIDTH-1:0] s1_o;
  logic [REG_DATA_WIDTH-1:0] s2_o;
  logic [31:0]               imm_o;
  logic [REG_DATA_WIDTH-1:0] store_data_o;
  logic [4:0]                rd_o;
  logic                      reg_we_o;
  logic                      mem_rd_o;
  logic                      mem_wr_o;
  logic [2:0]                mem_funct3_o;
  logic                      branch_o;
  logic                      jal_o;
  logic                      jalr_o;
  logic [2:0]                br_cond_o;
  logic [31:0]               pc_o;
  logic                      illegal_o;

  int n_checks = 0;
  int n_pass   = 0;

  core_decode_stage #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .instr_i      (instr_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .rs1_addr_o   (rs1_addr_o),
    .rs2_addr_o   (rs2_addr_o),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .alu_op_o     (alu_op_o),
    .s1_o         (s1_o),
    .s2_o         (s2_o),
    .imm_o        (imm_o),
    .store_data_o (store_data_o),
    .rd_o         (rd_o),
    .reg_we_o     (reg_we_o),
    .mem_rd_o     (mem_rd_o),
    .mem_wr_o     (mem_wr_o),
    .mem_funct3_o (mem_funct3_o),
    .branch_o     (branch_o),
    .jal_o        (jal_o),
    .jalr_o       (jalr_o),
    .br_cond_o    (br_cond_o),
    .pc_o         (pc_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Present one instruction for a single accepting cycle; returns #1 after
  // the accepting edge, when the bundle is visible.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2);
    @(negedge clk);
    in_valid_i = 1'b1; instr_i = ins; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid_i = 1'b0; instr_i = '0; pc_i = '0; flush_i = 1'b0;
    rs1_data_i = '0; rs2_data_i = '0; out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",    out_valid_o, 0);
    chk("rst_pc",       pc_o, RST_PC);
    chk("rst_alu_op",   alu_op_o, ALU_OP_ADD);
    chk("rst_reg_we",   reg_we_o, 0);
    chk("rst_s1",       s1_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    @(negedge clk); rst = 1'b0;

    // addi x1,x0,5
    send(32'h0050_0093, 32'h0, 32'h0, 32'h0);
    chk("addi_valid",  out_valid_o, 1);
    chk("addi_alu",    alu_op_o, ALU_OP_ADD);
    chk("addi_s1",     s1_o, 0);
    chk("addi_s2",     s2_o, 5);
    chk("addi_rd",     rd_o, 1);
    chk("addi_reg_we", reg_we_o, 1);

    // sub x3,x1,x2: also the combinational read addresses
    @(negedge clk); instr_i = 32'h4020_81B3; #1;
    chk("sub_rs1_addr", rs1_addr_o, 1);
    chk("sub_rs2_addr", rs2_addr_o, 2);
    send(32'h4020_81B3, 32'h4, 32'd10, 32'd3);
    chk("sub_alu", alu_op_o, ALU_OP_SUB);
    chk("sub_s1",  s1_o, 10);
    chk("sub_s2",  s2_o, 3);
    chk("sub_rd",  rd_o, 3);

    // srai x5,x6,3
    send(32'h4033_5293, 32'h8, 32'h8000_0000, 32'h0);
    chk("srai_alu",   alu_op_o, ALU_OP_SRA);
    chk("srai_shamt", {27'd0, s2_o[4:0]}, 3);
    chk("srai_s1",    s1_o, 32'h8000_0000);
    chk("srai_ill",   illegal_o, 0);

    // beq x1,x2,+8 at 0x100
    send(32'h0020_8463, 32'h100, 32'd7, 32'd7);
    chk("beq_branch", branch_o, 1);
    chk("beq_alu",    alu_op_o, ALU_OP_SUB);
    chk("beq_imm",    imm_o, 8);
    chk("beq_reg_we", reg_we_o, 0);
    chk("beq_pc",     pc_o, 32'h100);
    chk("beq_cond",   br_cond_o, 0);

    // lw x4,-4(x2)
    send(32'hFFC1_2203, 32'h104, 32'h200, 32'h0);
    chk("lw_mem_rd", mem_rd_o, 1);
    chk("lw_s1",     s1_o, 32'h200);
    chk("lw_s2",     s2_o, 32'hFFFF_FFFC);
    chk("lw_funct3", mem_funct3_o, 2);
    chk("lw_reg_we", reg_we_o, 1);
    chk("lw_rd",     rd_o, 4);

    // auipc x7,0x12345 at 0x40
    send(32'h1234_5397, 32'h40, 32'hDEAD_BEEF, 32'h0);
    chk("auipc_s1",  s1_o, 32'h40);
    chk("auipc_s2",  s2_o, 32'h1234_5000);
    chk("auipc_alu", alu_op_o, ALU_OP_ADD);
    chk("auipc_rd",  rd_o, 7);

    // sw x2,8(x1)
    send(32'h0020_A423, 32'h44, 32'h300, 32'hCAFE_F00D);
    chk("sw_mem_wr", mem_wr_o, 1);
    chk("sw_reg_we", reg_we_o, 0);
    chk("sw_s2",     s2_o, 8);
    chk("sw_data",   store_data_o, 32'hCAFE_F00D);
    chk("sw_imm",    imm_o, 8);

    // jal x1,+16 at 0x48
    send(32'h0100_00EF, 32'h48, 32'h0, 32'h0);
    chk("jal_flag", jal_o, 1);
    chk("jal_s1",   s1_o, 32'h48);
    chk("jal_s2",   s2_o, 4);
    chk("jal_imm",  imm_o, 16);
    chk("jal_we",   reg_we_o, 1);
    idle();
    chk("drain_valid", out_valid_o, 0);

    // Backpressure: hold addi x2,x0,7 while addi x3,x0,9 waits
    @(negedge clk);
    out_ready_i = 1'b0; in_valid_i = 1'b1; instr_i = 32'h0070_0113; pc_i = 32'h200;
    rs1_data_i = '0;
    @(posedge clk); #1;
    chk("stall_x_valid", out_valid_o, 1);
    chk("stall_x_s2",    s2_o, 7);
    instr_i = 32'h0090_0193; pc_i = 32'h204;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_hold_valid", out_valid_o, 1);
      chk("stall_hold_s2",    s2_o, 7);
      chk("stall_hold_rd",    rd_o, 2);
      chk("stall_hold_pc",    pc_o, 32'h200);
      chk("stall_in_ready",   in_ready_o, 0);
    end
    @(negedge clk); out_ready_i = 1'b1; #1;
    chk("stall_release_ready", in_ready_o, 1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    chk("stall_y_valid", out_valid_o, 1);
    chk("stall_y_s2",    s2_o, 9);
    chk("stall_y_rd",    rd_o, 3);
    chk("stall_y_pc",    pc_o, 32'h204);
    idle();
    chk("stall_no_dup", out_valid_o, 0);

    // Flush drops the incoming instruction
    @(negedge clk);
    in_valid_i = 1'b1; instr_i = 32'h0050_0093; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush_in_valid", out_valid_o, 0);

    // Flush drops a held bundle and the one waiting behind it
    @(negedge clk);
    out_ready_i = 1'b0; in_valid_i = 1'b1; instr_i = 32'h0070_0113;
    @(posedge clk); #1;
    chk("flush_held_pre", out_valid_o, 1);
    @(negedge clk); flush_i = 1'b1; instr_i = 32'h0090_0193;
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    chk("flush_held_valid", out_valid_o, 0);
    idle();
    chk("flush_held_after", out_valid_o, 0);

    // Illegal encodings still deliver a bundle
    send(32'h0000_0073, 32'h300, 32'h0, 32'h0);
    chk("ecall_valid",   out_valid_o, 1);
    chk("ecall_illegal", illegal_o, 1);
    chk("ecall_reg_we",  reg_we_o, 0);
    send(32'h0000_007F, 32'h304, 32'h0, 32'h0);
    chk("opc7f_illegal", illegal_o, 1);
    chk("opc7f_alu",     alu_op_o, ALU_OP_ADD);
    send(32'h0220_81B3, 32'h308, 32'd1, 32'd2);
    chk("mul_illegal",   illegal_o, 1);
    chk("mul_reg_we",    reg_we_o, 0);
    chk("mul_alu",       alu_op_o, ALU_OP_ADD);
    send(32'h4030_9293, 32'h30C, 32'd1, 32'd0);
    chk("slli_f7_illegal", illegal_o, 1);
    send(32'hFFC1_3203, 32'h310, 32'h200, 32'h0);
    chk("ld_illegal",    illegal_o, 1);
    chk("ld_mem_rd",     mem_rd_o, 0);

    // addi x0,x0,5: write to x0 suppressed
    send(32'h0050_0013, 32'h314, 32'h0, 32'h0);
    chk("x0_reg_we",  reg_we_o, 0);
    chk("x0_illegal", illegal_o, 0);
    chk("x0_s2",      s2_o, 5);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
